// File: rtl/batcharger_pkg.sv
// Shared definitions for the battery-charger mode controller.
// State encodings are fixed because the state is exported for debug.
package batcharger_pkg;

    localparam int SW = 3;

    typedef logic [SW-1:0] state_t;

    localparam state_t ST_IDLE  = 3'b000;
    localparam state_t ST_WAIT  = 3'b001;
    localparam state_t ST_TC    = 3'b010;
    localparam state_t ST_CC    = 3'b011;
    localparam state_t ST_CV    = 3'b100;
    localparam state_t ST_END   = 3'b101;
    localparam state_t ST_FAULT = 3'b110;

endpackage

// File: rtl/batcharger_cv_timer.sv
// Constant-voltage phase timer: counts cycles while run is high,
// flags expiry exactly tmax*PRESCALE cycles after run rises.
module batcharger_cv_timer #(
    parameter int DW       = 8,
    parameter int PRESCALE = 255
) (
    input  logic          clk,
    input  logic          rstz,
    input  logic          run,
    input  logic [DW-1:0] tmax,
    output logic          expired
);

    localparam int TW = DW + $clog2(PRESCALE + 1);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;
    logic [TW-1:0] limit;

    assign limit = TW'(tmax) * TW'(PRESCALE);

    always_comb begin
        cnt_d = '0;
        if (run) begin
            cnt_d = (&cnt_q) ? cnt_q : cnt_q + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // tmax of zero disables the timeout altogether
    assign expired = run && (tmax != '0) && (cnt_q == limit - TW'(1));

endmodule

// File: rtl/batcharger_ctrl_gen2.sv
// Charge-mode Moore FSM (TC/CC/CV) with CV timeout, temperature fault
// with exit hysteresis, and monitor-enable / status decode.
module batcharger_ctrl_gen2
    import batcharger_pkg::*;
#(
    parameter int DW        = 8,
    parameter int PRESCALE  = 255,
    parameter int TEMP_HYST = 2
) (
    input  logic          clk,
    input  logic          rstz,
    input  logic          en,
    input  logic          vtok,
    input  logic [DW-1:0] vbat,
    input  logic [DW-1:0] ibat,
    input  logic [DW-1:0] tbat,
    input  logic [DW-1:0] vcutoff,
    input  logic [DW-1:0] vpreset,
    input  logic [DW-1:0] iend,
    input  logic [DW-1:0] tempmin,
    input  logic [DW-1:0] tempmax,
    input  logic [DW-1:0] tmax,
    output logic          tc,
    output logic          cc,
    output logic          cv,
    output logic          imonen,
    output logic          vmonen,
    output logic          tmonen,
    output logic [2:0]    state,
    output logic          done,
    output logic          fault
);

    state_t state_q;
    state_t state_d;
    logic   tok;
    logic   hok;
    logic   timeout;

    logic [DW:0] tb_x;
    logic [DW:0] hyst;

    assign tb_x = {1'b0, tbat};
    assign hyst = (DW+1)'(TEMP_HYST);
    assign tok  = (tbat >= tempmin) && (tbat <= tempmax);
    // margins added on the tbat/tempmin side so nothing can underflow
    assign hok  = (tb_x >= {1'b0, tempmin} + hyst) &&
                  (tb_x + hyst <= {1'b0, tempmax});

    batcharger_cv_timer #(
        .DW       (DW),
        .PRESCALE (PRESCALE)
    ) u_timer (
        .clk     (clk),
        .rstz    (rstz),
        .run     (state_q == ST_CV),
        .tmax    (tmax),
        .expired (timeout)
    );

    always_comb begin
        state_d = state_q;
        if (!en || !vtok) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  state_d = ST_WAIT;
                ST_WAIT: begin
                    if (tok) begin
                        if (vbat <= vcutoff)      state_d = ST_TC;
                        else if (vbat <= vpreset) state_d = ST_CC;
                        else                      state_d = ST_CV;
                    end
                end
                ST_TC: begin
                    if (!tok)                state_d = ST_FAULT;
                    else if (vbat > vcutoff) state_d = ST_CC;
                end
                ST_CC: begin
                    if (!tok)                state_d = ST_FAULT;
                    else if (vbat > vpreset) state_d = ST_CV;
                end
                ST_CV: begin
                    if (!tok)                      state_d = ST_FAULT;
                    else if (ibat < iend || timeout) state_d = ST_END;
                end
                ST_END: begin
                    if (vbat <= vcutoff)     state_d = ST_TC;
                    else if (vbat < vpreset) state_d = ST_CC;
                end
                ST_FAULT: begin
                    if (hok) state_d = ST_WAIT;
                end
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign state  = state_q;
    assign tc     = (state_q == ST_TC);
    assign cc     = (state_q == ST_CC);
    assign cv     = (state_q == ST_CV);
    assign imonen = tc || cc || cv;
    assign vmonen = (state_q != ST_IDLE);
    assign tmonen = (state_q != ST_IDLE);
    assign done   = (state_q == ST_END);
    assign fault  = (state_q == ST_FAULT);

endmodule
